// File: rtl/axi_sram_slave.sv
// AXI4 responder serving one read or write burst at a time from a single-port
// synchronous SRAM; AR/AW contention is resolved round-robin.
module axi_sram_slave #(
   parameter int ID_BITS       = 8,
   parameter int ADDR_BITS     = 32,
   parameter int DATA_BITS     = 32,
   parameter int LEN_BITS      = 8,
   parameter int MEM_ADDR_BITS = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   // write address
   input  logic [ID_BITS-1:0]       awid,
   input  logic [ADDR_BITS-1:0]     awaddr,
   input  logic [LEN_BITS-1:0]      awlen,
   input  logic [2:0]               awsize,
   input  logic [1:0]               awburst,
   input  logic                     awvalid,
   output logic                     awready,
   // write data
   input  logic [DATA_BITS-1:0]     wdata,
   input  logic [DATA_BITS/8-1:0]   wstrb,
   input  logic                     wlast,
   input  logic                     wvalid,
   output logic                     wready,
   // write response
   output logic [ID_BITS-1:0]       bid,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   // read address
   input  logic [ID_BITS-1:0]       arid,
   input  logic [ADDR_BITS-1:0]     araddr,
   input  logic [LEN_BITS-1:0]      arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic                     arvalid,
   output logic                     arready,
   // read data
   output logic [ID_BITS-1:0]       rid,
   output logic [DATA_BITS-1:0]     rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready,
   // SRAM macro
   output logic                     sram_cs,
   output logic [DATA_BITS/8-1:0]   sram_we,
   output logic [MEM_ADDR_BITS-1:0] sram_a,
   output logic [DATA_BITS-1:0]     sram_di,
   input  logic [DATA_BITS-1:0]     sram_do
);

   localparam int CNT_BITS = LEN_BITS + 1;
   localparam logic PRIO_READ  = 1'b0;
   localparam logic PRIO_WRITE = 1'b1;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {IDLE, R_DATA, W_DATA, B_RESP} state_e;

   state_e                 state_q;
   logic                   prio_q;
   logic [ID_BITS-1:0]     id_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [LEN_BITS-1:0]    len_q;
   logic [1:0]             burst_q;
   logic [CNT_BITS-1:0]    beat_q;
   logic                   rvalid_q;
   logic                   rfresh_q;
   logic                   rlast_q;
   logic [DATA_BITS-1:0]   rhold_q;
   logic                   bvalid_q;

   logic                   ar_hs;
   logic                   aw_hs;
   logic                   r_hs;
   logic                   rd_issue;
   logic                   wr_beat;
   logic                   last_beat;
   logic                   beats_left;
   logic [ADDR_BITS-1:0]   addr_d;
   logic                   unused_ok;

   assign unused_ok = ^{awsize, arsize, wlast};

   assign arready = (state_q == IDLE) && arvalid && (!awvalid || prio_q == PRIO_READ);
   assign awready = (state_q == IDLE) && awvalid && (!arvalid || prio_q == PRIO_WRITE);
   assign ar_hs   = arvalid && arready;
   assign aw_hs   = awvalid && awready;

   assign last_beat  = (beat_q == {1'b0, len_q});
   assign beats_left = (beat_q <= {1'b0, len_q});
   assign addr_d     = (burst_q == BURST_FIXED) ? addr_q : addr_q + ADDR_BITS'(4);

   // A read may issue only when the output slot is empty or draining this cycle.
   assign rd_issue = (state_q == R_DATA) && beats_left && (!rvalid_q || rready);
   assign r_hs     = rvalid_q && rready;
   assign wready   = (state_q == W_DATA);
   assign wr_beat  = wvalid && wready;

   always_comb begin
      sram_cs = rd_issue || wr_beat;
      sram_we = wr_beat ? wstrb : '0;
      sram_a  = addr_q[MEM_ADDR_BITS+1:2];
      sram_di = wdata;
   end

   // Freshly read data comes straight from the macro; it is parked in rhold_q
   // if the master stalls, so the macro output need not stay stable.
   assign rdata  = rfresh_q ? sram_do : rhold_q;
   assign rvalid = rvalid_q;
   assign rlast  = rlast_q;
   assign rid    = id_q;
   assign rresp  = 2'b00;
   assign bvalid = bvalid_q;
   assign bid    = id_q;
   assign bresp  = 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= PRIO_READ;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         rvalid_q <= 1'b0;
         rfresh_q <= 1'b0;
         rlast_q  <= 1'b0;
         rhold_q  <= '0;
         bvalid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ar_hs) begin
                  id_q    <= arid;
                  addr_q  <= araddr;
                  len_q   <= arlen;
                  burst_q <= arburst;
                  beat_q  <= '0;
                  prio_q  <= PRIO_WRITE;
                  state_q <= R_DATA;
               end else if (aw_hs) begin
                  id_q    <= awid;
                  addr_q  <= awaddr;
                  len_q   <= awlen;
                  burst_q <= awburst;
                  beat_q  <= '0;
                  prio_q  <= PRIO_READ;
                  state_q <= W_DATA;
               end
            end
            R_DATA: begin
               if (rd_issue) begin
                  rvalid_q <= 1'b1;
                  rfresh_q <= 1'b1;
                  rlast_q  <= last_beat;
                  beat_q   <= beat_q + CNT_BITS'(1);
                  addr_q   <= addr_d;
               end else if (r_hs) begin
                  rvalid_q <= 1'b0;
                  rfresh_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (rlast_q) state_q <= IDLE;
               end else if (rfresh_q) begin
                  rhold_q  <= sram_do;
                  rfresh_q <= 1'b0;
               end
            end
            W_DATA: begin
               if (wr_beat) begin
                  beat_q <= beat_q + CNT_BITS'(1);
                  addr_q <= addr_d;
                  if (last_beat) begin
                     bvalid_q <= 1'b1;
                     state_q  <= B_RESP;
                  end
               end
            end
            B_RESP: begin
               if (bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: behavioural SRAM, shadow memory and a
// queue of expected read beats.
module tb_axi_sram_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata, sram_di, sram_do;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready, sram_cs;
   logic [3:0]  wstrb, sram_we;
   logic [13:0] sram_a;

   logic        pre_we;
   logic [13:0] pre_a;
   logic [31:0] pre_d;
   logic [31:0] mem     [0:16383];
   logic [31:0] exp_mem [0:16383];
   logic [31:0] exp_q   [$];
   logic [31:0] wbuf    [0:255];
   logic [3:0]  sbuf    [0:255];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   axi_sram_slave dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
   );

   // Synchronous SRAM: byte-enabled writes, read data valid the following cycle.
   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (sram_cs) begin
         if (sram_we == 4'b0000) sram_do <= mem[sram_a];
         else for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic [13:0] wa(input logic [31:0] a, input int i, input logic [1:0] b);
      logic [31:0] x;
      x = (b == 2'b00) ? a : a + 32'(4 * i);
      return x[15:2];
   endfunction

   task automatic preload(input int w, input logic [31:0] d);
      pre_we = 1'b1; pre_a = 14'(w); pre_d = d; exp_mem[w] = d;
      tick;
      pre_we = 1'b0;
   endtask

   task automatic post_ar(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
      arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
   endtask

   task automatic post_aw(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
      awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
   endtask

   // mode 0: rready held high, 1: pattern 1,0,0,1,1,1 then high, 2: random
   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int mode);
      int pat [0:5];
      int lat, pidx, first_lat, guard;
      bit done, held;
      logic [31:0] hd;
      logic hl;
      pat = '{1, 0, 0, 1, 1, 1};
      post_ar(id, addr, len, burst);
      #1;
      chk("idle_cs", 64'(sram_cs), 64'(0));
      chk("ar_first_arready", 64'(arready), 64'(1));
      chk("ar_first_awready", 64'(awready), 64'(0));
      guard = 0;
      while (!arready && guard < 20) begin tick; #1; guard++; end
      chk("ar_handshake", 64'(arready), 64'(1));
      for (int i = 0; i <= len; i++) exp_q.push_back(exp_mem[wa(addr, i, burst)]);
      tick;
      arvalid = 1'b0;
      lat = 1; pidx = 0; done = 1'b0; held = 1'b0; first_lat = -1;
      while (!done && lat < 8 * len + 40) begin
         case (mode)
            1:       rready = (pidx < 6) ? (pat[pidx] != 0) : 1'b1;
            2:       rready = 1'($urandom_range(0, 1));
            default: rready = 1'b1;
         endcase
         #1;
         if (held) begin
            chk("r_hold_valid", 64'(rvalid), 64'(1));
            chk("r_hold_data", 64'(rdata), 64'(hd));
            chk("r_hold_last", 64'(rlast), 64'(hl));
         end
         held = 1'b0;
         if (rvalid) begin
            if (first_lat < 0) begin
               first_lat = lat;
               chk("r_first_latency", 64'(lat), 64'(2));
            end
            pidx++;
            if (rready) begin
               chk("r_data", 64'(rdata), 64'(exp_q[0]));
               chk("r_last", 64'(rlast), 64'(exp_q.size() == 1));
               chk("r_id", 64'(rid), 64'(id));
               chk("r_resp", 64'(rresp), 64'(0));
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  done = 1'b1;
                  if (mode == 0) chk("r_back_to_back", 64'(lat - first_lat), 64'(len));
               end
            end else begin
               held = 1'b1; hd = rdata; hl = rlast;
            end
         end
         tick;
         lat++;
      end
      chk("r_burst_complete", 64'(done), 64'(1));
      exp_q.delete();
      rready = 1'b0;
      #1;
      chk("r_drop_after_last", 64'(rvalid), 64'(0));
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int bdelay);
      int guard;
      logic [13:0] w;
      post_aw(id, addr, len, burst);
      #1;
      chk("aw_first_awready", 64'(awready), 64'(1));
      chk("aw_first_arready", 64'(arready), 64'(0));
      guard = 0;
      while (!awready && guard < 20) begin tick; #1; guard++; end
      chk("aw_handshake", 64'(awready), 64'(1));
      tick;
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         w = wa(addr, i, burst);
         wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len);
         #1;
         chk("w_ready", 64'(wready), 64'(1));
         chk("w_cs", 64'(sram_cs), 64'(1));
         chk("w_we", 64'(sram_we), 64'(sbuf[i]));
         chk("w_addr", 64'(sram_a), 64'(w));
         chk("b_early", 64'(bvalid), 64'(0));
         for (int b = 0; b < 4; b++)
            if (sbuf[i][b]) exp_mem[w][8*b +: 8] = wbuf[i][8*b +: 8];
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      #1;
      chk("w_cs_off", 64'(sram_cs), 64'(0));
      for (int k = 0; k < bdelay; k++) begin
         chk("b_valid_held", 64'(bvalid), 64'(1));
         tick;
         #1;
      end
      bready = 1'b1;
      #1;
      chk("b_valid", 64'(bvalid), 64'(1));
      chk("b_id", 64'(bid), 64'(id));
      chk("b_resp", 64'(bresp), 64'(0));
      tick;
      bready = 1'b0;
      #1;
      chk("b_drop", 64'(bvalid), 64'(0));
   endtask

   initial begin
      rst = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
      awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      tick; tick;
      #1;
      chk("rst_arready", 64'(arready), 64'(0));
      chk("rst_awready", 64'(awready), 64'(0));
      chk("rst_wready", 64'(wready), 64'(0));
      chk("rst_rvalid", 64'(rvalid), 64'(0));
      chk("rst_bvalid", 64'(bvalid), 64'(0));
      chk("rst_sram_cs", 64'(sram_cs), 64'(0));
      chk("rst_sram_we", 64'(sram_we), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_rid", 64'(rid), 64'(0));
      chk("rst_rlast", 64'(rlast), 64'(0));
      preload(4, 32'hDEADBEEF);
      preload(0, 32'h11);
      preload(1, 32'h22);
      preload(2, 32'h33);
      preload(3, 32'h44);
      rst = 1'b0;
      tick;

      // Four alternating transactions with the other channel always pending.
      post_aw(8'h21, 32'h100, 1, 2'b01);
      do_read(8'h5A, 32'h10, 0, 2'b01, 0);
      wbuf[0] = 32'h1111_0001; sbuf[0] = 4'hF;
      wbuf[1] = 32'h2222_0002; sbuf[1] = 4'hF;
      post_ar(8'h42, 32'h0, 3, 2'b01);
      do_write(8'h21, 32'h100, 1, 2'b01, 0);
      post_aw(8'h3C, 32'h8, 2, 2'b00);
      do_read(8'h42, 32'h0, 3, 2'b01, 1);
      wbuf[0] = 32'hA1; sbuf[0] = 4'hF;
      wbuf[1] = 32'hB2; sbuf[1] = 4'hF;
      wbuf[2] = 32'hC3; sbuf[2] = 4'h3;
      do_write(8'h3C, 32'h8, 2, 2'b00, 3);
      chk("fixed_word2", 64'(mem[2]), 64'(32'h0000_00C3));
      chk("fixed_word3_untouched", 64'(mem[3]), 64'(32'h44));

      do_read(8'h43, 32'h0, 3, 2'b01, 0);

      // Full-length burst: 256 beats out and back.
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(8'hA5, 32'h0, 255, 2'b01, 1);
      do_read(8'hA6, 32'h0, 255, 2'b01, 0);

      // Reset while the second beat of a 4-beat read is on the bus.
      post_ar(8'h77, 32'h0, 3, 2'b01);
      #1;
      chk("rst_test_arready", 64'(arready), 64'(1));
      tick;
      arvalid = 1'b0; rready = 1'b1;
      tick;
      #1;
      chk("rst_test_beat0_valid", 64'(rvalid), 64'(1));
      chk("rst_test_beat0_data", 64'(rdata), 64'(exp_mem[0]));
      tick;
      #1;
      chk("rst_test_beat1_valid", 64'(rvalid), 64'(1));
      rst = 1'b1;
      #1;
      chk("rst_mid_rvalid", 64'(rvalid), 64'(0));
      chk("rst_mid_rlast", 64'(rlast), 64'(0));
      chk("rst_mid_cs", 64'(sram_cs), 64'(0));
      tick;
      rst = 1'b0; rready = 1'b0;
      #1;
      chk("rst_release_rvalid", 64'(rvalid), 64'(0));
      chk("rst_release_bvalid", 64'(bvalid), 64'(0));

      // Priority returns to READ after reset; then a write wrapping the SRAM space.
      post_aw(8'h99, 32'hFFF8, 3, 2'b01);
      do_read(8'h88, 32'h4, 2, 2'b01, 2);
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = $urandom;
         sbuf[i] = 4'($urandom_range(1, 15));
      end
      do_write(8'h99, 32'hFFF8, 3, 2'b01, 2);
      do_read(8'h9A, 32'hFFF8, 3, 2'b01, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 responder (slave) that serves read and write bursts from bus masters, including DMA_master and the CPU masters, into a single-port synchronous SRAM macro. It handles one transaction at a time, read or write, and arbitrates simultaneous AR/AW requests round-robin. It supports the FIXED and INCR burst types the DMA issues, and streams read data at one beat per cycle.

Parameters:
ID_BITS, 8, width of arid/awid/rid/bid (slave-side ID incl. master tag)
ADDR_BITS, 32, AXI address width
DATA_BITS, 32, AXI data width (one word)
LEN_BITS, 8, arlen/awlen width
MEM_ADDR_BITS, 14, SRAM word-address width

Ports:
clk  in  1  clock
rst  in  1  reset
awid/awaddr/awlen/awsize/awburst  in  ID_BITS/ADDR_BITS/LEN_BITS/3/2  write address
awvalid in 1; awready out 1
wdata/wstrb/wlast  in  DATA_BITS/4/1  write data (wlast ignored)
wvalid in 1; wready out 1
bid/bresp  out  ID_BITS/2  write response
bvalid out 1; bready in 1
arid/araddr/arlen/arsize/arburst  in  ID_BITS/ADDR_BITS/LEN_BITS/3/2  read address
arvalid in 1; arready out 1
rid/rdata/rresp/rlast  out  ID_BITS/DATA_BITS/2/1  read data
rvalid out 1; rready in 1
sram_cs  out  1  SRAM chip select
sram_we  out  4  byte write enables, active high
sram_a  out  MEM_ADDR_BITS  word address
sram_di  out  DATA_BITS  write data
sram_do  in  DATA_BITS  read data, valid the cycle after a read access

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset state: IDLE, prio=READ. All valid/ready, sram_cs and sram_we are 0. All ID, data, address and counter registers are 0.
- States: IDLE, R_DATA, W_DATA, B_RESP.
- IDLE, address acceptance:
  - arready = arvalid && (!awvalid || prio==READ).
  - awready = awvalid && (!arvalid || prio==WRITE).
  - Only one handshake occurs per cycle.
- Address handshake:
  - Latches id, addr, len and burst, and clears the beat counter.
  - Flips prio to the other direction.
  - AR -> R_DATA; AW -> W_DATA.
- Address generation:
  - sram_a = cur_addr[MEM_ADDR_BITS+1:2].
  - FIXED (00): address is constant.
  - INCR (01), and WRAP (10) treated as INCR: +4 per beat, wrapping modulo 2^ADDR_BITS.
  - awsize/arsize are ignored; transfers are always a word.
- R_DATA:
  - One-entry output register holds rdata/rvalid.
  - An SRAM read (cs=1, we=0) issues in cycle t when beats remain un-issued and either (rvalid=0 and no read in flight) or (rvalid && rready).
  - The output register loads sram_do at t+1 and sets rvalid.
  - First rvalid appears 2 cycles after the AR handshake. With rready held high, throughput is 1 beat/cycle.
  - With rready low, rdata/rvalid/rlast are held stable and no further read issues.
  - rlast = (beat index == len). rid = latched id. rresp = 00.
  - rvalid && rready && rlast -> IDLE, and rvalid drops next cycle.
- W_DATA:
  - wready=1.
  - Each wvalid&&wready writes wdata to the current address with sram_cs=1 and sram_we=wstrb in the same cycle (combinational SRAM strobe).
  - The burst ends on the handshake of beat index == len -> B_RESP. wlast is not checked.
- B_RESP: bvalid=1, bid = latched id, bresp=00. bvalid is held until bready, then -> IDLE (new address acceptable next cycle).
- len=0 is a single beat. len=255 is 256 beats; the beat counter is LEN_BITS+1 wide to avoid wrap.
- Mid-transaction reset: returns to IDLE immediately. Partial writes stay in SRAM. No response is sent.
- sram_cs=0 whenever no access is issued. sram_di = wdata.

Test Plan:
- Single read: araddr=0x0000_0010, arlen=0, INCR, rready=1, SRAM word 4 = 0xDEADBEEF -> rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF, rlast=1, rid echoes arid.
- INCR read, arlen=3, addr 0x0, words 0..3 = 0x11,0x22,0x33,0x44:
  - rready toggles 1,0,0,1,1,1 -> beats 0x11..0x44 in order, rdata held while rready=0.
  - rlast only on 0x44.
  - With rready=1 throughout, 4 consecutive beat cycles.
- FIXED write, awlen=2, addr 0x8, wdata 0xA1/0xB2/0xC3, wstrb 0xF,0xF,0x3 -> all three SRAM writes hit word 2 with we as given; word 2 lower half = 0x00C3, upper half = 0x0000 (upper from 0xB2). bvalid after beat 3, held 3 cycles until bready, bid echoed.
- Simultaneous arvalid and awvalid after reset -> AR accepted first. On re-assertion of both after the read completes, AW is accepted. Alternation holds over 4 transactions.
- len=255 INCR write from 0x0 then read back -> 256 beats each. Data matches, rlast on beat 256, no early termination.
- Assert rst during beat 2 of a 4-beat read -> rvalid=0 within the reset cycle, state IDLE. A new AR is accepted normally after release.
